// File: rtl/mac_pipe_acc_if.sv
// mac_pipe_acc_if: operation request / result handshake bundle
// for the pipelined multiply-accumulate unit.
interface mac_pipe_acc_if #(
    parameter int WIDTH = 32
);
    localparam int RW = 2 * WIDTH;

    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] in_m1;
    logic [WIDTH-1:0] in_m2;
    logic [WIDTH-1:0] in_addend;
    logic             in_signed;
    logic             in_acc;
    logic             in_clear;
    logic             out_valid;
    logic             out_ready;
    logic [RW-1:0]    out_result;
    logic             out_is_acc;

    modport master (
        output in_valid,
        output in_m1,
        output in_m2,
        output in_addend,
        output in_signed,
        output in_acc,
        output in_clear,
        output out_ready,
        input  in_ready,
        input  out_valid,
        input  out_result,
        input  out_is_acc
    );

    modport slave (
        input  in_valid,
        input  in_m1,
        input  in_m2,
        input  in_addend,
        input  in_signed,
        input  in_acc,
        input  in_clear,
        input  out_ready,
        output in_ready,
        output out_valid,
        output out_result,
        output out_is_acc
    );
endinterface

// File: rtl/mac_pipe_acc.sv
// mac_pipe_acc: three-stage multiply-accumulate pipeline with a
// single global stall and an accumulator that lives in the output stage.
module mac_pipe_acc #(
    parameter int WIDTH = 32
) (
    input logic           CLK,
    input logic           RST,
    mac_pipe_acc_if.slave bus
);
    localparam int RW = 2 * WIDTH;

    logic             adv;

    logic             s1_v;
    logic [WIDTH-1:0] s1_m1;
    logic [WIDTH-1:0] s1_m2;
    logic [WIDTH-1:0] s1_add;
    logic             s1_sgn;
    logic             s1_acc;
    logic             s1_clr;

    logic             s2_v;
    logic [RW-1:0]    s2_prod;
    logic [RW-1:0]    s2_add;
    logic             s2_acc;
    logic             s2_clr;

    logic             out_v;
    logic [RW-1:0]    out_res;
    logic             out_acc;
    logic [RW-1:0]    acc;

    logic [RW-1:0]    m1_x;
    logic [RW-1:0]    m2_x;
    logic [RW-1:0]    add_x;
    logic [RW-1:0]    sum;

    assign adv            = !out_v || bus.out_ready;
    assign bus.in_ready   = adv;
    assign bus.out_valid  = out_v;
    assign bus.out_result = out_res;
    assign bus.out_is_acc = out_acc;

    // Sign bits are only replicated in signed mode; otherwise zero-extend.
    always_comb begin
        m1_x  = {{WIDTH{s1_sgn & s1_m1[WIDTH-1]}}, s1_m1};
        m2_x  = {{WIDTH{s1_sgn & s1_m2[WIDTH-1]}}, s1_m2};
        add_x = {{WIDTH{s1_sgn & s1_add[WIDTH-1]}}, s1_add};
    end

    assign sum = s2_prod + (s2_acc ? (s2_clr ? '0 : acc) : s2_add);

    always_ff @(posedge CLK) begin
        if (RST) begin
            s1_v    <= 1'b0;
            s1_m1   <= '0;
            s1_m2   <= '0;
            s1_add  <= '0;
            s1_sgn  <= 1'b0;
            s1_acc  <= 1'b0;
            s1_clr  <= 1'b0;
            s2_v    <= 1'b0;
            s2_prod <= '0;
            s2_add  <= '0;
            s2_acc  <= 1'b0;
            s2_clr  <= 1'b0;
            out_v   <= 1'b0;
            out_res <= '0;
            out_acc <= 1'b0;
            acc     <= '0;
        end else if (adv) begin
            s1_v    <= bus.in_valid;
            s1_m1   <= bus.in_m1;
            s1_m2   <= bus.in_m2;
            s1_add  <= bus.in_addend;
            s1_sgn  <= bus.in_signed;
            s1_acc  <= bus.in_acc;
            s1_clr  <= bus.in_clear;
            s2_v    <= s1_v;
            s2_prod <= m1_x * m2_x;
            s2_add  <= add_x;
            s2_acc  <= s1_acc;
            s2_clr  <= s1_clr;
            out_v   <= s2_v;
            // Bubbles leave the result and accumulator untouched.
            if (s2_v) begin
                out_res <= sum;
                out_acc <= s2_acc;
                if (s2_acc) begin
                    acc <= sum;
                end
            end
        end
    end
endmodule

// File: tb/tb_mac_pipe_acc.sv
// tb_mac_pipe_acc: scoreboard bench for the MAC pipeline, with directed
// narrow-width cases and randomized traffic on a 32-bit instance.
module tb_mac_pipe_acc;
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    mac_pipe_acc_if #(.WIDTH(32)) b32();
    mac_pipe_acc_if #(.WIDTH(8))  b8();
    mac_pipe_acc_if #(.WIDTH(4))  b4();

    mac_pipe_acc #(.WIDTH(32)) u32 (.CLK(clk), .RST(rst), .bus(b32));
    mac_pipe_acc #(.WIDTH(8))  u8  (.CLK(clk), .RST(rst), .bus(b8));
    mac_pipe_acc #(.WIDTH(4))  u4  (.CLK(clk), .RST(rst), .bus(b4));

    typedef struct {
        logic [63:0] res;
        bit          is_acc;
    } exp_t;

    exp_t        q[$];
    logic [63:0] macc = '0;
    int          total = 0;
    int          bad = 0;
    int          stall_left = 0;
    bit          rnd_ready = 1'b0;
    int          waits = 0;

    task automatic chk(input string name, input logic [63:0] act,
                       input logic [63:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", name, act, req);
        end
    endtask

    function automatic logic [63:0] ext(input logic [31:0] x, input bit s);
        if (s) return longint'($signed(x));
        return {32'b0, x};
    endfunction

    // Output-side consumer for the 32-bit instance.
    always @(negedge clk) begin
        if (stall_left > 0) begin
            b32.out_ready = 1'b0;
            stall_left--;
        end else if (rnd_ready) begin
            b32.out_ready = ($urandom_range(3) != 0);
        end else begin
            b32.out_ready = 1'b1;
        end
    end

    // Monitor: pops the scoreboard whenever a result is consumed.
    logic        prev_v = 1'b0;
    logic        prev_r = 1'b0;
    logic        prev_rst = 1'b1;
    logic [63:0] prev_res = '0;
    logic        prev_acc = 1'b0;
    always @(negedge clk) begin
        exp_t e;
        #2;
        if (!rst) begin
            if (!prev_rst && prev_v && !prev_r) begin
                chk("hold_valid", 64'(b32.out_valid), 64'd1);
                chk("hold_result", b32.out_result, prev_res);
                chk("hold_is_acc", 64'(b32.out_is_acc), 64'(prev_acc));
            end
            chk("in_ready", 64'(b32.in_ready),
                64'(!(b32.out_valid && !b32.out_ready)));
            if (b32.out_valid && b32.out_ready) begin
                if (q.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL unexpected_output: got %0h want none",
                             b32.out_result);
                end else begin
                    e = q.pop_front();
                    chk("result", b32.out_result, e.res);
                    chk("is_acc", 64'(b32.out_is_acc), 64'(e.is_acc));
                end
            end
        end
        prev_v   = b32.out_valid;
        prev_r   = b32.out_ready;
        prev_res = b32.out_result;
        prev_acc = b32.out_is_acc;
        prev_rst = rst;
    end

    task automatic issue32(input logic [31:0] m1, input logic [31:0] m2,
                           input logic [31:0] ad, input bit s, input bit a,
                           input bit c, input bit use_want,
                           input logic [63:0] want);
        logic [63:0] sum;
        int          n;
        exp_t        e;
        @(negedge clk);
        b32.in_m1     = m1;
        b32.in_m2     = m2;
        b32.in_addend = ad;
        b32.in_signed = s;
        b32.in_acc    = a;
        b32.in_clear  = c;
        b32.in_valid  = 1'b1;
        #1;
        n = 0;
        while (!b32.in_ready && n < 200) begin
            @(negedge clk);
            #1;
            n++;
            waits++;
        end
        if (!b32.in_ready) begin
            total++;
            bad++;
            $display("FAIL accept_timeout: got in_ready=0 want 1");
        end else begin
            sum = ext(m1, s) * ext(m2, s)
                + (a ? (c ? 64'd0 : macc) : ext(ad, s));
            if (a) macc = sum;
            e.res    = use_want ? want : sum;
            e.is_acc = a;
            q.push_back(e);
        end
    endtask

    task automatic idle32();
        @(negedge clk);
        b32.in_valid = 1'b0;
    endtask

    task automatic drain();
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            #3;
            if (q.size() == 0 && !b32.out_valid) break;
        end
        chk("drain_left", 64'(q.size()), 64'd0);
    endtask

    task automatic run8(input logic [7:0] m1, input logic [7:0] m2,
                        input logic [7:0] ad, input bit s,
                        input logic [15:0] want);
        @(negedge clk);
        b8.in_m1     = m1;
        b8.in_m2     = m2;
        b8.in_addend = ad;
        b8.in_signed = s;
        b8.in_acc    = 1'b0;
        b8.in_clear  = 1'b0;
        b8.in_valid  = 1'b1;
        #1 chk("w8_in_ready", 64'(b8.in_ready), 64'd1);
        @(negedge clk);
        b8.in_valid = 1'b0;
        #1 chk("w8_lat1", 64'(b8.out_valid), 64'd0);
        @(negedge clk);
        #1 chk("w8_lat2", 64'(b8.out_valid), 64'd0);
        @(negedge clk);
        #1 chk("w8_valid", 64'(b8.out_valid), 64'd1);
        chk("w8_result", 64'(b8.out_result), 64'(want));
    endtask

    task automatic run4(input logic [3:0] m1, input logic [3:0] m2,
                        input logic [3:0] ad, input bit s,
                        input logic [7:0] want);
        @(negedge clk);
        b4.in_m1     = m1;
        b4.in_m2     = m2;
        b4.in_addend = ad;
        b4.in_signed = s;
        b4.in_acc    = 1'b0;
        b4.in_clear  = 1'b0;
        b4.in_valid  = 1'b1;
        @(negedge clk);
        b4.in_valid = 1'b0;
        repeat (2) @(negedge clk);
        #1 chk("w4_valid", 64'(b4.out_valid), 64'd1);
        chk("w4_result", 64'(b4.out_result), 64'(want));
    endtask

    initial begin
        b32.in_valid = 1'b1;
        b32.in_m1 = 32'd9;
        b32.in_m2 = 32'd9;
        b32.in_addend = 32'd1;
        b32.in_signed = 1'b0;
        b32.in_acc = 1'b1;
        b32.in_clear = 1'b0;
        b32.out_ready = 1'b1;
        b8.in_valid = 1'b0;
        b8.in_m1 = '0;
        b8.in_m2 = '0;
        b8.in_addend = '0;
        b8.in_signed = 1'b0;
        b8.in_acc = 1'b0;
        b8.in_clear = 1'b0;
        b8.out_ready = 1'b1;
        b4.in_valid = 1'b0;
        b4.in_m1 = '0;
        b4.in_m2 = '0;
        b4.in_addend = '0;
        b4.in_signed = 1'b0;
        b4.in_acc = 1'b0;
        b4.in_clear = 1'b0;
        b4.out_ready = 1'b1;

        // Reset with a request pending: nothing may be captured.
        repeat (2) @(negedge clk);
        #1;
        chk("rst_in_ready", 64'(b32.in_ready), 64'd1);
        chk("rst_out_valid", 64'(b32.out_valid), 64'd0);
        chk("rst_out_result", b32.out_result, 64'd0);
        chk("rst_is_acc", 64'(b32.out_is_acc), 64'd0);
        @(negedge clk);
        rst = 1'b0;
        b32.in_valid = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            #1 chk("rst_no_capture", 64'(b32.out_valid), 64'd0);
        end

        run8(8'd200, 8'd100, 8'd255, 1'b0, 16'd20255);
        run8(8'hFF, 8'h80, 8'hFE, 1'b1, 16'h007E);
        run4(4'hF, 4'hF, 4'hF, 1'b0, 8'hF0);
        run4(4'hF, 4'hF, 4'hF, 1'b1, 8'h00);

        // Accumulator chain, back-to-back.
        waits = 0;
        issue32(3, 4, 0, 1'b0, 1'b1, 1'b1, 1'b1, 64'd12);
        issue32(5, 6, 0, 1'b0, 1'b1, 1'b0, 1'b1, 64'd42);
        issue32(1, 1, 7, 1'b0, 1'b0, 1'b0, 1'b1, 64'd8);
        issue32(2, 2, 0, 1'b0, 1'b1, 1'b0, 1'b1, 64'd46);
        idle32();
        chk("no_bubble_waits", 64'(waits), 64'd0);
        drain();

        // Stream with a 4-cycle consumer stall after the first result.
        waits = 0;
        fork
            begin
                for (int i = 0; i < 6; i++)
                    issue32($urandom, $urandom, $urandom, 1'($urandom),
                            1'($urandom), 1'b0, 1'b0, '0);
                idle32();
            end
            begin
                bit seen;
                seen = 1'b0;
                for (int i = 0; i < 20 && !seen; i++) begin
                    @(negedge clk);
                    #3;
                    if (b32.out_valid) begin
                        stall_left = 4;
                        seen = 1'b1;
                    end
                end
                chk("stall_first_result", 64'(seen), 64'd1);
            end
        join
        chk("stall_blocked", 64'(waits > 0), 64'd1);
        drain();

        // Reset with three ops in flight.
        issue32(7, 7, 1, 1'b0, 1'b0, 1'b0, 1'b0, '0);
        issue32(8, 8, 1, 1'b0, 1'b1, 1'b0, 1'b0, '0);
        issue32(9, 9, 1, 1'b0, 1'b1, 1'b0, 1'b0, '0);
        @(negedge clk);
        rst = 1'b1;
        b32.in_valid = 1'b0;
        q.delete();
        macc = '0;
        @(negedge clk);
        rst = 1'b0;
        #1 chk("flush_out_valid", 64'(b32.out_valid), 64'd0);
        issue32(2, 2, 0, 1'b0, 1'b1, 1'b1, 1'b1, 64'd4);
        idle32();
        drain();

        // Random traffic with a random consumer.
        rnd_ready = 1'b1;
        for (int i = 0; i < 300; i++)
            issue32($urandom, $urandom, $urandom, 1'($urandom),
                    1'($urandom), ($urandom_range(7) == 0), 1'b0, '0);
        idle32();
        drain();
        rnd_ready = 1'b0;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
